// File: rtl/sigma_delta_dac.sv
`default_nettype none
// ============================================================================
// Module      : sigma_delta_dac
// Description : First-order sigma-delta DAC. Accepts unsigned offset-binary
//               PCM samples at clk/BOSR through a valid/ready handshake. Each
//               sample is held for one sample period and modulated by a
//               first-order error-feedback loop onto a 1-bit registered pin.
//               An external RC filter on dac_pin recovers VCC*code/2^WDTH.
//
// Parameters  : BOSR  oversampling ratio, clk cycles per sample (power of 2, >= 4)
//               WDTH  sample width in bits
//
// Ports       : clk          bit clock (sample rate * BOSR)
//               rst          synchronous active-high reset
//               dac_input    PCM sample code
//               dac_valid    dac_input is valid
//               dac_ready    holding register can accept a sample
//               dac_pin      registered 1-bit modulator output
//               dac_strobe   one-cycle pulse at every sample-period boundary
//               dac_underrun one-cycle pulse on a boundary with no sample
//
// Options     : SIGMA_DELTA_DAC_INTERP_EN - when defined, the modulator input
//               ramps linearly from the previous sample to the current one
//               over each sample period (adds one sample period of latency).
//
// Revision    : 1.0 - initial release
// ============================================================================
module sigma_delta_dac #(
    parameter int BOSR = 256,
    parameter int WDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WDTH-1:0] dac_input,
    input  logic            dac_valid,
    output logic            dac_ready,
    output logic            dac_pin,
    output logic            dac_strobe,
    output logic            dac_underrun
);

    localparam int                 c_cnt_w    = $clog2(BOSR);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BOSR - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    // Registered state
    logic [c_cnt_w-1:0] cnt_q,       cnt_d;
    logic [WDTH-1:0]    hold_q,      hold_d;
    logic               hold_full_q, hold_full_d;
    logic [WDTH-1:0]    cur_q,       cur_d;
    logic [WDTH-1:0]    acc_q,       acc_d;
    logic               pin_q,       pin_d;

    // Combinational helpers
    logic               w_load;
    logic               w_xfer;
    logic [WDTH-1:0]    w_new;
    logic [WDTH-1:0]    w_mod_in;
    logic [WDTH:0]      w_sum;

    assign w_load = (cnt_q == c_cnt_last);
    assign w_xfer = dac_valid && dac_ready;

    // Sample taken at a boundary: the held one if present, otherwise a
    // same-cycle transfer bypasses the holding register, otherwise repeat.
    assign w_new  = hold_full_q ? hold_q : (w_xfer ? dac_input : cur_q);

    assign dac_ready    = !hold_full_q && !rst;
    assign dac_strobe   = w_load && !rst;
    assign dac_underrun = dac_strobe && !hold_full_q && !w_xfer;
    assign dac_pin      = pin_q;

`ifdef SIGMA_DELTA_DAC_INTERP_EN
    logic signed [WDTH:0]         step_q, step_d;
    logic signed [WDTH+c_cnt_w:0] ip_q,   ip_d;
    logic signed [WDTH:0]         w_step_new;
    logic                         w_ip_unused;

    assign w_step_new  = $signed({1'b0, w_new}) - $signed({1'b0, cur_q});
    assign w_mod_in    = ip_q[WDTH+c_cnt_w-1:c_cnt_w];
    assign w_ip_unused = ^{ip_q[WDTH+c_cnt_w], ip_q[c_cnt_w-1:0]};

    // The ramp restarts from the outgoing sample at each boundary and adds
    // one step per cycle, landing on the incoming sample one period later.
    always_comb begin
        step_d = step_q;
        ip_d   = ip_q + $signed({{c_cnt_w{step_q[WDTH]}}, step_q});
        if (w_load) begin
            step_d = w_step_new;
            ip_d   = $signed({1'b0, cur_q, {c_cnt_w{1'b0}}});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= '0;
            ip_q   <= '0;
        end else begin
            step_q <= step_d;
            ip_q   <= ip_d;
        end
    end
`else
    assign w_mod_in = cur_q;
`endif

    // Carry out of the error accumulator is the output bit; the remainder is
    // kept so the quantisation error carries across sample boundaries.
    assign w_sum = {1'b0, acc_q} + {1'b0, w_mod_in};

    always_comb begin
        cnt_d       = cnt_q + c_cnt_one;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cur_d       = cur_q;
        acc_d       = w_sum[WDTH-1:0];
        pin_d       = w_sum[WDTH];
        if (w_load) begin
            cur_d       = w_new;
            hold_full_d = 1'b0;
        end else if (w_xfer) begin
            hold_d      = dac_input;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cur_q       <= '0;
            acc_q       <= '0;
            pin_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cur_q       <= cur_d;
            acc_q       <= acc_d;
            pin_q       <= pin_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sigma_delta_dac.sv
`default_nettype none
// ============================================================================
// Module      : tb_sigma_delta_dac
// Description : Self-checking bench for sigma_delta_dac (default build).
//               The reference keeps the running sum of all codes fed to the
//               modulator; the pin is 1 exactly when that sum crosses a
//               multiple of 2^WDTH. Sample scheduling follows the
//               period/holding-register rules directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sigma_delta_dac;

    localparam int BOSR = 256;
    localparam int WDTH = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [WDTH-1:0] dac_input;
    logic            dac_valid;
    logic            dac_ready;
    logic            dac_pin;
    logic            dac_strobe;
    logic            dac_underrun;

    always #5 clk = ~clk;

    sigma_delta_dac #(.BOSR(BOSR), .WDTH(WDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .dac_input    (dac_input),
        .dac_valid    (dac_valid),
        .dac_ready    (dac_ready),
        .dac_pin      (dac_pin),
        .dac_strobe   (dac_strobe),
        .dac_underrun (dac_underrun)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    int     m_cnt;
    bit     m_hold_full;
    int     m_hold;
    int     m_cur;
    longint m_sum;
    bit     m_pin;

    // Observation helpers
    int win_acc;
    int last_win;
    int n_under;
    bit last_xfer_obs;
    int n_stream;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_cnt       = 0;
        m_hold_full = 1'b0;
        m_hold      = 0;
        m_cur       = 0;
        m_sum       = 0;
        m_pin       = 1'b0;
    endtask

    // One clock cycle: check the current cycle's outputs, then advance.
    task automatic tick();
        bit     e_ready, e_strobe, e_xfer, e_under;
        bit     in_rst, in_valid;
        int     in_data;
        longint s_new;
        #1;
        in_rst   = rst;
        in_valid = dac_valid;
        in_data  = int'(dac_input);
        e_ready  = !m_hold_full && !in_rst;
        e_strobe = !in_rst && (m_cnt == BOSR - 1);
        e_xfer   = in_valid && e_ready;
        e_under  = e_strobe && !m_hold_full && !e_xfer;
        chk("ready",    dac_ready,    e_ready);
        chk("strobe",   dac_strobe,   e_strobe);
        chk("underrun", dac_underrun, e_under);
        chk("pin",      dac_pin,      m_pin);
        last_xfer_obs = dac_valid && dac_ready;
        if (dac_underrun === 1'b1) n_under++;
        // Pins seen at cnt=1..BOSR-1,0 all derive from one loaded sample.
        if (m_cnt == 1) win_acc = int'(dac_pin);
        else            win_acc += int'(dac_pin);
        if (m_cnt == 0) last_win = win_acc;
        @(posedge clk);
        if (in_rst) begin
            model_reset();
        end else begin
            s_new = m_sum + longint'(m_cur);
            m_pin = (s_new >> WDTH) != (m_sum >> WDTH);
            m_sum = s_new;
            if (m_cnt == BOSR - 1) begin
                if (m_hold_full) begin
                    m_cur       = m_hold;
                    m_hold_full = 1'b0;
                end else if (e_xfer) begin
                    m_cur = in_data;
                end
            end else if (e_xfer) begin
                m_hold      = in_data;
                m_hold_full = 1'b1;
            end
            m_cnt = (m_cnt + 1) % BOSR;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [WDTH-1:0] code);
        bit done;
        done      = 1'b0;
        dac_valid = 1'b1;
        dac_input = code;
        for (int i = 0; i < 3 * BOSR && !done; i++) begin
            tick();
            done = last_xfer_obs;
        end
        dac_valid = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic align_to(input int c);
        for (int i = 0; i < BOSR + 1 && m_cnt != c; i++) tick();
        if (m_cnt != c) chk("align_timeout", 0, 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        dac_valid = 1'b1;
        dac_input = WDTH'($urandom);
        win_acc   = 0;
        last_win  = 0;
        n_under   = 0;
        model_reset();
        @(posedge clk);
        @(negedge clk);

        // Reset held with valid asserted
        idle(5);
        rst       = 1'b0;
        dac_valid = 1'b0;
        #1 chk("ready_after_rst", dac_ready, 1);
        idle(BOSR - 1);
        #1 chk("first_strobe", dac_strobe, 1);
        chk("first_underrun", dac_underrun, 1);
        tick();

        // Constant codes and their ones density
        send(16'h8000);
        idle(2 * BOSR + 2);
        chk("win_8000", last_win, 128);
        send(16'h4000);
        idle(2 * BOSR + 2);
        chk("win_4000", last_win, 64);
        send(16'h0000);
        idle(2 * BOSR + 2);
        chk("win_0000", last_win, 0);
        send(16'hFFFF);
        idle(2 * BOSR + 2);
        chk("win_ffff", last_win >= BOSR - 1, 1);

        // Streaming with valid held high
        align_to(0);
        dac_valid = 1'b1;
        dac_input = WDTH'($urandom);
        n_stream  = 0;
        for (int i = 0; i < 8 * BOSR; i++) begin
            tick();
            if (last_xfer_obs) begin
                n_stream++;
                dac_input = dac_input + 1'b1;
            end
        end
        dac_valid = 1'b0;
        chk("stream_xfers", n_stream, 8);

        // Source stops: underruns repeat the last code
        send(16'h2000);
        idle(BOSR + 2);
        n_under = 0;
        idle(3 * BOSR);
        chk("underrun_pulses", n_under, 3);
        chk("win_2000", last_win, 32);
        align_to(10);
        send(16'h6000);
        n_under = 0;
        idle(BOSR);
        chk("underrun_cleared", n_under, 0);

        // Bypass: transfer exactly on the boundary with hold empty
        align_to(20);
        align_to(BOSR - 1);
        dac_valid = 1'b1;
        dac_input = WDTH'($urandom);
        #1 chk("bypass_strobe", dac_strobe, 1);
        chk("bypass_underrun", dac_underrun, 0);
        chk("bypass_ready", dac_ready, 1);
        tick();
        dac_valid = 1'b0;
        align_to(BOSR - 1);
        #1 chk("bypass_hold_empty", dac_underrun, 1);
        tick();

        // Reset mid-operation discards the held sample
        align_to(5);
        send(WDTH'($urandom));
        idle(20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1 chk("midrst_ready", dac_ready, 1);
        chk("midrst_pin", dac_pin, 0);
        idle(BOSR - 1);
        #1 chk("midrst_hold_discarded", dac_underrun, 1);
        tick();

        // Random samples with random gaps
        for (int k = 0; k < 20; k++) begin
            send(WDTH'($urandom));
            idle(int'($urandom_range(0, 2 * BOSR)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
